serial_pattern_gen: RTL

Serial bit-stream generator that drives the single-bit `x` input of the team's serial sequence detectors, one bit per clock. It takes a parallel word of up to WIDTH bits through a valid/ready handshake and shifts it out MSB-first, optionally repeating it. It replaces hand-written bench loops as the stimulus source for detector blocks and for on-chip self-test of serial links.

---
 rtl/serial_pattern_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: accepts a parallel word over valid/ready and
// shifts it out MSB-first on x, one bit per clock, optionally repeating it.
module serial_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_repeat,
  input  logic             stop,
  output logic             x,
  output logic             x_valid,
  output logic [LEN_W-1:0] bit_cnt,
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // S_IDLE | waiting for a word; in_ready=1
  // S_SEND | driving one pattern bit per cycle on x
  // S_GAP  | idle spacing between repetitions (GAP>0 only)
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam int               GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             x_d, x_valid_d, busy_d, done_d;
  logic [LEN_W-1:0] bit_cnt_d;

  logic [LEN_W-1:0] len_in;
  logic [WIDTH-1:0] word_in;
  logic             last_bit;
  logic             rep_live;

  // Words are stored left-aligned so the first bit is always at the MSB.
  assign len_in   = (in_len == '0 || in_len > WIDTH_L) ? WIDTH_L : in_len;
  assign word_in  = in_data << (WIDTH_L - len_in);
  assign last_bit = (bit_cnt == len_q - LEN_W'(1));
  assign rep_live = rep_q & ~stop;
  assign in_ready = (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    saved_d   = saved_q;
    len_d     = len_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    bit_cnt_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_SEND;
          saved_d   = word_in;
          len_d     = len_in;
          rep_d     = in_repeat;
          x_d       = word_in[WIDTH-1];
          shreg_d   = word_in << 1;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_SEND: begin
        rep_d  = rep_live;
        busy_d = 1'b1;
        if (!last_bit) begin
          x_d       = shreg_q[WIDTH-1];
          shreg_d   = shreg_q << 1;
          x_valid_d = 1'b1;
          bit_cnt_d = bit_cnt + LEN_W'(1);
        end else if (rep_live && GAP == 0) begin
          x_d       = saved_q[WIDTH-1];
          shreg_d   = saved_q << 1;
          x_valid_d = 1'b1;
        end else if (rep_live) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        rep_d = rep_live;
        if (!rep_live) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_q == '0) begin
          state_d   = S_SEND;
          x_d       = saved_q[WIDTH-1];
          shreg_d   = saved_q << 1;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_d  = gap_q - GAP_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      saved_q <= '0;
      len_q   <= '0;
      rep_q   <= 1'b0;
      gap_q   <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      saved_q <= saved_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      x       <= x_d;
      x_valid <= x_valid_d;
      bit_cnt <= bit_cnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
